alu_flag_stage: RTL

- Registered execute-output stage directly downstream of arithmeticUnit.
- Captures result/carryOut each accepted operation, derives zero/negative (and optionally overflow) flags, presents them to writeback/branch logic over a valid/ready handshake.
- 2-entry skid buffer: full throughput with a registered inReady, no combinational ready path upstream.

---
 rtl/alu_flag_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_flag_stage.sv
// Registered execute-output stage: captures ALU result/carry, derives zero/negative(/overflow) flags.
// Latency: one cycle from accept to out* when the stage is empty, or holds one entry that drains that cycle.
// Backpressure: 2-entry skid buffer; inReady is registered and drops only when both entries are full.
// Optional overflow flag: define ALU_OVERFLOW_FLAG_EN to compute and store it; otherwise outOverflow is 0.

module alu_flag_stage #(
  parameter int SIZE        = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [SIZE-1:0]        result,
  input  logic                   carryOut,
  input  logic                   operandAMsb,
  input  logic                   operandBMsb,
  input  logic                   control,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [SIZE-1:0]        outResult,
  output logic                   outCarry,
  output logic                   outZero,
  output logic                   outNegative,
  output logic                   outOverflow,
  output logic [COUNT_WIDTH-1:0] opCount
);

  // EMPTY: nothing held; ONE: main entry valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // One stored operation: result plus the flags derived at accept time.
  typedef struct packed {
    logic [SIZE-1:0] res;
    logic            carry;
    logic            zero;
    logic            neg;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic            ovf;
`endif
  } entry_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   accept;

  assign accept = inValid && inReady;

  // Flags are derived from the upstream values present at the accepting edge.
  always_comb begin
    in_entry       = '0;
    in_entry.res   = result;
    in_entry.carry = carryOut;
    in_entry.zero  = (result == '0);
    in_entry.neg   = result[SIZE-1];
`ifdef ALU_OVERFLOW_FLAG_EN
    // Signed overflow: add overflows when like-signed operands give a differently
    // signed result; subtract when unlike-signed operands do.
    if (control)
      in_entry.ovf = (operandAMsb != operandBMsb) && (result[SIZE-1] != operandAMsb);
    else
      in_entry.ovf = (operandAMsb == operandBMsb) && (result[SIZE-1] != operandAMsb);
`endif
  end

`ifndef ALU_OVERFLOW_FLAG_EN
  // Operand sign bits and the add/subtract select only matter for the overflow flag.
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = ^{operandAMsb, operandBMsb, control};
`endif

  // Skid-buffer control: state, entry storage, registered handshake outputs and counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      outValid <= 1'b0;
      inReady  <= 1'b1;
      opCount  <= '0;
    end else begin
      // Counts each accept exactly once, wrapping naturally at the counter width.
      if (accept)
        opCount <= opCount + 1'b1;

      case (state)
        EMPTY: begin
          if (accept) begin
            main_q   <= in_entry;
            outValid <= 1'b1;
            state    <= ONE;
          end
        end

        ONE: begin
          if (accept && outReady) begin
            // Simultaneous drain and refill keeps a single entry in flight.
            main_q <= in_entry;
          end else if (accept) begin
            // Downstream stalled: park the new op in the skid entry and stop accepting.
            skid_q  <= in_entry;
            inReady <= 1'b0;
            state   <= FULL;
          end else if (outReady) begin
            outValid <= 1'b0;
            state    <= EMPTY;
          end
        end

        FULL: begin
          // inReady is low here, so the only event is the drain of the main entry.
          if (outReady) begin
            main_q  <= skid_q;
            inReady <= 1'b1;
            state   <= ONE;
          end
        end

        default: begin
          state    <= EMPTY;
          outValid <= 1'b0;
          inReady  <= 1'b1;
        end
      endcase
    end
  end

  assign outResult   = main_q.res;
  assign outCarry    = main_q.carry;
  assign outZero     = main_q.zero;
  assign outNegative = main_q.neg;
`ifdef ALU_OVERFLOW_FLAG_EN
  assign outOverflow = main_q.ovf;
`else
  assign outOverflow = 1'b0;
`endif

endmodule
